// File: rtl/cmp_serial.sv
// Serial magnitude comparator: walks DIGIT-bit groups MSB first and reports
// l/e/g after a fixed N = WIDTH/DIGIT steps, in unsigned or two's complement mode.
module cmp_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              dec_q, dec_d;
    logic              gt_q, gt_d;
    logic              done_q, done_d;
    logic              l_q, l_d;
    logic              e_q, e_d;
    logic              g_q, g_d;

    logic [DIGIT-1:0]  ga_s, gb_s;
    logic              last_s;
    logic              step_dec_s;
    logic              step_gt_s;

    // State register and all datapath flops, reset has priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dec_q   <= dec_d;
            gt_q    <= gt_d;
            done_q  <= done_d;
            l_q     <= l_d;
            e_q     <= e_d;
            g_q     <= g_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Current step: top group of each shifted operand; first difference wins and sticks
    always_comb begin
        ga_s       = a_q[WIDTH-1 -: DIGIT];
        gb_s       = b_q[WIDTH-1 -: DIGIT];
        last_s     = (state_q == RUN) && (cnt_q == CW'(N - 1));
        step_dec_s = dec_q | (ga_s != gb_s);
        if (dec_q) begin
            step_gt_s = gt_q;
        end else begin
            step_gt_s = (ga_s > gb_s);
        end
    end

    // Datapath: load with MSB offset conversion, then shift one group per step
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        dec_d  = dec_q;
        gt_d   = gt_q;
        done_d = 1'b0;
        l_d    = l_q;
        e_d    = e_q;
        g_d    = g_q;
        if ((state_q == IDLE) && start) begin
            cnt_d = {CW{1'b0}};
            a_d   = a ^ (sgn ? MSB_MASK : {WIDTH{1'b0}});
            b_d   = b ^ (sgn ? MSB_MASK : {WIDTH{1'b0}});
            dec_d = 1'b0;
            gt_d  = 1'b0;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + CW'(1);
            a_d   = a_q << DIGIT;
            b_d   = b_q << DIGIT;
            dec_d = step_dec_s;
            gt_d  = step_gt_s;
            if (last_s) begin
                done_d = 1'b1;
                l_d    = step_dec_s & ~step_gt_s;
                e_d    = ~step_dec_s;
                g_d    = step_dec_s & step_gt_s;
            end else begin
                done_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs: busy decodes the state flop, the rest come straight from flops
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        l    = l_q;
        e    = e_q;
        g    = g_q;
    end

endmodule

// File: tb/tb_cmp_serial.sv
// Directed and table-driven bench for cmp_serial: 8/2 vectors and corner
// sequences, plus sweeps of the 6/3 and 4/4 configurations against a reference compare.
module tb_cmp_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       sgn_in = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic [1:0] sel = 2'd0;

    logic start0, start1, start2;
    logic busy0, done0, l0, e0, g0;
    logic busy1, done1, l1, e1, g1;
    logic busy2, done2, l2, e2, g2;
    logic busy_m, done_m;
    logic [2:0] leg_m;
    int n_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign start0 = start & (sel == 2'd0);
    assign start1 = start & (sel == 2'd1);
    assign start2 = start & (sel == 2'd2);

    cmp_serial #(.WIDTH(8), .DIGIT(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .sgn(sgn_in), .a(a_in), .b(b_in),
        .busy(busy0), .done(done0), .l(l0), .e(e0), .g(g0));
    cmp_serial #(.WIDTH(6), .DIGIT(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .sgn(sgn_in), .a(a_in[5:0]), .b(b_in[5:0]),
        .busy(busy1), .done(done1), .l(l1), .e(e1), .g(g1));
    cmp_serial #(.WIDTH(4), .DIGIT(4)) u2 (
        .clk(clk), .rst(rst), .start(start2), .sgn(sgn_in), .a(a_in[3:0]), .b(b_in[3:0]),
        .busy(busy2), .done(done2), .l(l2), .e(e2), .g(g2));

    always_comb begin
        case (sel)
            2'd0:    begin busy_m = busy0; done_m = done0; leg_m = {l0, e0, g0}; n_m = 4; end
            2'd1:    begin busy_m = busy1; done_m = done1; leg_m = {l1, e1, g1}; n_m = 2; end
            default: begin busy_m = busy2; done_m = done2; leg_m = {l2, e2, g2}; n_m = 1; end
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic [2:0] leg;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // {l,e,g} of x vs y taken as w-bit values, signed when s=1
    function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y,
                                           input logic s, input int w);
        int sx, sy;
        sx = int'(x);
        sy = int'(y);
        if (s && x[w-1]) sx = sx - (1 << w);
        if (s && y[w-1]) sy = sy - (1 << w);
        if (sx < sy) return 3'b100;
        if (sx == sy) return 3'b010;
        return 3'b001;
    endfunction

    // One start pulse, scrambled inputs while running, latency/result/hold checks
    task automatic run_cmp(input logic [7:0] ta, input logic [7:0] tb,
                           input logic ts, input logic [2:0] exp_leg, input string nm);
        int cyc;
        @(negedge clk);
        a_in = ta; b_in = tb; sgn_in = ts; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a_in = ~ta; b_in = ~tb; sgn_in = ~ts;
        cyc = 0;
        while (done_m !== 1'b1 && cyc < 20) begin
            chk({nm, "_busy"}, 32'(busy_m), 32'd1);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done"}, 32'(done_m), 32'd1);
        chk({nm, "_latency"}, 32'(cyc), 32'(n_m));
        chk({nm, "_leg"}, 32'(leg_m), 32'(exp_leg));
        chk({nm, "_busy_end"}, 32'(busy_m), 32'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk({nm, "_done_pulse"}, 32'(done_m), 32'd0);
            chk({nm, "_hold"}, 32'(leg_m), 32'(exp_leg));
        end
    endtask

    vec_t vt[10];
    vec_t bp[4];

    initial begin
        int cyc, since, idx;
        logic [7:0] xa, xb;
        logic xs;

        vt[0] = '{8'h5A, 8'h5A, 1'b0, 3'b010};
        vt[1] = '{8'h80, 8'h7F, 1'b0, 3'b001};
        vt[2] = '{8'h80, 8'h7F, 1'b1, 3'b100};
        vt[3] = '{8'hFF, 8'h01, 1'b1, 3'b100};
        vt[4] = '{8'hC3, 8'hC1, 1'b0, 3'b001};
        vt[5] = '{8'h40, 8'hC3, 1'b0, 3'b100};
        vt[6] = '{8'h40, 8'hC3, 1'b1, 3'b001};
        vt[7] = '{8'h00, 8'h00, 1'b1, 3'b010};
        vt[8] = '{8'hFF, 8'h00, 1'b0, 3'b001};
        vt[9] = '{8'h7F, 8'h80, 1'b1, 3'b001};

        bp[0] = '{8'h80, 8'h7F, 1'b0, 3'b001};
        bp[1] = '{8'h12, 8'h34, 1'b0, 3'b100};
        bp[2] = '{8'h80, 8'h7F, 1'b1, 3'b100};
        bp[3] = '{8'h5A, 8'h5A, 1'b1, 3'b010};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            sel = 2'(u);
            #1;
            chk("reset_busy", 32'(busy_m), 32'd0);
            chk("reset_done", 32'(done_m), 32'd0);
            chk("reset_leg", 32'(leg_m), 32'd0);
        end
        sel = 2'd0;

        for (int i = 0; i < 10; i++) begin
            run_cmp(vt[i].a, vt[i].b, vt[i].sgn, vt[i].leg, $sformatf("vec%0d", i));
        end

        // start held high: the done cycle is IDLE, so each reload is one edge after done
        @(negedge clk);
        a_in = bp[0].a; b_in = bp[0].b; sgn_in = bp[0].sgn; start = 1'b1;
        idx = 0; since = 0; cyc = 0;
        while (idx < 4 && cyc < 60) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            since++;
            if (done_m === 1'b1) begin
                chk($sformatf("b2b_leg%0d", idx), 32'(leg_m), 32'(bp[idx].leg));
                chk($sformatf("b2b_period%0d", idx), 32'(since), 32'd5);
                since = 0;
                idx++;
                if (idx < 4) begin
                    a_in = bp[idx].a; b_in = bp[idx].b; sgn_in = bp[idx].sgn;
                end else begin
                    start = 1'b0;
                end
            end else begin
                chk("b2b_busy", 32'(busy_m), 32'd1);
                a_in = 8'($urandom); b_in = 8'($urandom); sgn_in = 1'($urandom);
            end
        end
        chk("b2b_count", 32'(idx), 32'd4);

        // Abort: rst sampled on load+2
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h20; sgn_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy_m), 32'd0);
        chk("abort_done", 32'(done_m), 32'd0);
        chk("abort_leg", 32'(leg_m), 32'd0);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_done", 32'(done_m), 32'd0);
        end
        run_cmp(8'hC3, 8'hC1, 1'b0, 3'b001, "after_abort");

        sel = 2'd1;
        for (int i = 0; i < 300; i++) begin
            xa = 8'($urandom_range(0, 63));
            xb = (i % 8 == 0) ? xa : 8'($urandom_range(0, 63));
            xs = 1'($urandom);
            run_cmp(xa, xb, xs, ref_cmp(xa, xb, xs, 6), "w6d3");
        end

        sel = 2'd2;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int s = 0; s < 2; s++) begin
                    run_cmp(8'(x), 8'(y), 1'(s), ref_cmp(8'(x), 8'(y), 1'(s), 4), "w4d4");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
